// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds the digit count, blank code, saturation limit, FSM state type and
// the leading-zero blanking helper used when LEADING_ZERO_BLANK_EN is defined.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int unsigned NDIG       = 4;
    localparam int unsigned MAX_VAL    = 10**NDIG - 1;
    localparam bcd_digit_t  BLANK_CODE = 4'hA;

    // Replace zero digits from the MSD downward with BLANK_CODE, stopping at
    // the first non-zero digit. The least significant digit is always kept.
    function automatic logic [4*NDIG-1:0] blank_leading(input logic [4*NDIG-1:0] v);
        logic [4*NDIG-1:0] r;
        logic              lead;
        r    = v;
        lead = 1'b1;
        for (int unsigned i = NDIG - 1; i >= 1; i--) begin
            if (lead && (v[i*4 +: 4] == 4'h0)) begin
                r[i*4 +: 4] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-nibble shift-add-3 correction: a digit of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  bcd_digit_t din,
    output bcd_digit_t dout
);

    // Conditional +3 correction; inputs never exceed 9 in normal operation.
    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-add-3 step per clock.
// A conversion of a W-bit value takes W shift cycles plus one result cycle;
// values above MAX_VAL saturate to all nines and raise ovf.
// Optional feature: define LEADING_ZERO_BLANK_EN to replace leading zero
// digits (d3..d1) with BLANK_CODE in the presented result.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned W = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [W-1:0]      bin,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [4*NDIG-1:0] bcd
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned SW = 4 * NDIG;

    state_t          state;
    logic [W-1:0]    shreg;
    logic [SW-1:0]   scratch;
    logic [SW-1:0]   scratch_adj;
    logic [SW-1:0]   result;
    logic [SW+W-1:0] shifted;
    logic [CW-1:0]   bitcnt;
    logic            ovf_pend;

    // One correction cell per BCD digit of the scratch register.
    for (genvar g = 0; g < NDIG; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (scratch[g*4 +: 4]),
            .dout (scratch_adj[g*4 +: 4])
        );
    end

    // Corrected scratch and remaining binary bits shifted left as one word.
    always_comb begin
        shifted = {scratch_adj, shreg} << 1;
    end

    // Final digit pattern: saturate first, then optionally blank leading zeros.
    always_comb begin
        result = ovf_pend ? {NDIG{4'h9}} : scratch;
`ifdef LEADING_ZERO_BLANK_EN
        result = blank_leading(result);
`endif
    end

    // Conversion FSM with registered busy/done/bcd/ovf outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            shreg    <= '0;
            scratch  <= '0;
            bitcnt   <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // busy stays high through the done cycle, which runs in IDLE.
                    busy <= start;
                    if (start) begin
                        shreg    <= bin;
                        scratch  <= '0;
                        bitcnt   <= CW'(W - 1);
                        ovf_pend <= (32'(bin) > MAX_VAL);
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    scratch <= shifted[SW+W-1 -: SW];
                    shreg   <= shifted[W-1:0];
                    bitcnt  <= bitcnt - CW'(1);
                    if (bitcnt == '0) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    bcd   <= result;
                    ovf   <= ovf_pend;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases, start-while-busy,
// mid-conversion reset, back-to-back throughput and randomized values
// against an arithmetic decimal-digit reference.
module tb_bin2bcd_seq;

    localparam int unsigned W = 14;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [W-1:0] bin;
    logic        busy;
    logic        done;
    logic        ovf;
    logic [15:0] bcd;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .bcd   (bcd)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Decimal digits by division; saturate above 9999; blank by magnitude.
    function automatic logic [15:0] ref_bcd(input int unsigned v);
        int unsigned x;
        logic [15:0] r;
        x = (v > 9999) ? 9999 : v;
        r = {4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
`ifdef LEADING_ZERO_BLANK_EN
        if (x < 1000) r[15:12] = 4'hA;
        if (x < 100)  r[11:8]  = 4'hA;
        if (x < 10)   r[7:4]   = 4'hA;
`endif
        return r;
    endfunction

    // One conversion. intr_cyc: cycle at which a stray start is pulsed.
    // rst_cyc: cycle after whose edge reset is asserted (-1 = none).
    task automatic run(input int unsigned v, input int intr_cyc, input int rst_cyc);
        logic [15:0] prev_bcd;
        logic        prev_ovf;
        int          done_at;
        int          extra;
        int          busy_cnt;
        prev_bcd = bcd;
        prev_ovf = ovf;
        done_at  = 0;
        extra    = 0;
        busy_cnt = 0;
        @(negedge clk);
        bin   = W'(v);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        bin   = W'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
        for (int n = 1; n <= int'(W) + 6; n++) begin
            start = (n == intr_cyc);
            if (n == intr_cyc) bin = 14'd1111;
            @(posedge clk);
            #1;
            if (n == rst_cyc) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_bcd", 32'(bcd), 32'd0);
                check("rst_mid_flags", {29'd0, busy, done, ovf}, 32'd0);
            end
            @(negedge clk);
            if (n == rst_cyc) rst_n = 1'b1;
            if (busy) busy_cnt++;
            if (done) begin
                if (done_at == 0) begin
                    done_at = n;
                    check("busy_at_done", 32'(busy), 32'd1);
                end else begin
                    extra++;
                end
            end else if (done_at == 0 && rst_cyc < 0) begin
                if (n == 1 || n == int'(W)) check("hold_before_done", {15'd0, prev_ovf, prev_bcd}, {15'd0, ovf, bcd} ^ 32'd0);
            end
        end
        start = 1'b0;
        if (rst_cyc < 0) begin
            check($sformatf("latency_%0d", v), 32'(done_at), W + 1);
            check("single_done", 32'(extra), 32'd0);
            check("busy_cycles", 32'(busy_cnt), W + 1);
            check($sformatf("bcd_%0d", v), 32'(bcd), 32'(ref_bcd(v)));
            check($sformatf("ovf_%0d", v), 32'(ovf), 32'(v > 9999));
        end else begin
            check("rst_no_done", 32'(done_at + extra), 32'd0);
            check("rst_bcd_after", 32'(bcd), 32'd0);
            check("rst_flags_after", {30'd0, busy, ovf}, 32'd0);
        end
    endtask

    initial begin
        int unsigned bvals[12] = '{0, 1, 9, 10, 99, 100, 999, 1000, 9998, 9999, 10000, 16383};
        int unsigned pend[$];
        int unsigned v;
        int t;
        int last;
        int got;

        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        check("reset_bcd", 32'(bcd), 32'd0);
        check("reset_flags", {29'd0, busy, done, ovf}, 32'd0);
        rst_n = 1'b1;

        run(3363, -1, -1);

        // Asynchronous reset in idle, with start held: reset must win.
        @(negedge clk);
        rst_n = 1'b0;
        start = 1'b1;
        bin   = 14'd77;
        #1;
        check("idle_rst_bcd", 32'(bcd), 32'd0);
        check("idle_rst_flags", {29'd0, busy, done, ovf}, 32'd0);
        @(negedge clk);
        check("rst_beats_start", 32'(busy), 32'd0);
        start = 1'b0;
        rst_n = 1'b1;

        run(9999, -1, -1);
        run(0, -1, -1);
        run(12345, -1, -1);
        run(7, -1, -1);
        run(42, 5, -1);
        run(12000, -1, -1);
        run(500, -1, 7);
        run(2468, -1, -1);

        foreach (bvals[i]) run(bvals[i], -1, -1);
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) == 0) ? $urandom_range(9990, 10010) : $urandom_range(0, 16383);
            run(v, -1, -1);
        end

        // Back-to-back with start held high.
        @(negedge clk);
        v = $urandom_range(0, 16383);
        bin   = W'(v);
        start = 1'b1;
        pend.push_back(v);
        t    = 0;
        last = -1;
        got  = 0;
        for (int k = 0; k < 6 * (int'(W) + 2) + 4 && got < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            t++;
            if (done) begin
                v = pend.pop_front();
                check($sformatf("b2b_bcd_%0d", v), 32'(bcd), 32'(ref_bcd(v)));
                check($sformatf("b2b_ovf_%0d", v), 32'(ovf), 32'(v > 9999));
                if (last >= 0) check("b2b_period", 32'(t - last), W + 2);
                last = t;
                got++;
                v = $urandom_range(0, 16383);
                bin = W'(v);
                pend.push_back(v);
            end else begin
                bin = W'($urandom);
            end
        end
        start = 1'b0;
        check("b2b_count", 32'(got), 32'd6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
